matrix_storage_sequencer: RTL and testbench
===========================================

# matrix_storage_sequencer

Parametrised successor to the row/layer locator. Walks a stack of LAYERS matrices of ROWS x COLS elements and produces layer, row and column indices plus a flat storage address. It supports a row-major or column-major walk order, a start/busy/done run protocol, and a layer-skip command. It sits between the load controller and the matrix storage, and advances one element per accepted step.

## Interface
- ROWS, default 3: rows per matrix, >= 1.
- COLS, default 3: columns per matrix, >= 1.
- LAYERS, default 2: matrices per run, >= 1.
- ADDR_W, default 16: width of the flat address output.
- BASE, default 0: address of element (0,0,0).
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begins a run; honoured only in IDLE.
- col_major  in  1  walk order; sampled only on the accepted start (0 = row-major, 1 = column-major).
- step  in  1  advance one element; honoured only in RUN.
- skip_layer  in  1  jump to element (0,0) of the next layer; honoured only in RUN.
- layer_index  out  32  current layer.
- row_index  out  32  current row.
- col_index  out  32  current column.
- addr  out  ADDR_W  BASE + layer*ROWS*COLS + row*COLS + col, truncated modulo 2^ADDR_W.
- valid  out  1  high in RUN; indices and addr are meaningful.
- last_layer  out  1  high in RUN when layer_index == LAYERS-1.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.

## Operation
- States:
  - IDLE: reset state. Indices are 0, valid/busy/done are 0.
  - RUN
  - DONE
- IDLE -> RUN on start. Indices are cleared to 0 and col_major is latched into the mode register.
- RUN, step = 1, skip_layer = 0: advance by one element.
  - Row-major: col increments. At col == COLS-1, col -> 0 and row increments. At row == ROWS-1, row -> 0 and layer increments.
  - Column-major: row increments. At row == ROWS-1, row -> 0 and col increments. At col == COLS-1, col -> 0 and layer increments.
- RUN, skip_layer = 1: row -> 0, col -> 0, layer increments. skip_layer wins over a simultaneous step.
- Run end: a layer increment out of layer LAYERS-1 (by step or skip) goes to DONE instead. Indices return to 0.
- DONE -> IDLE unconditionally after one cycle. start in DONE is ignored.
- start in RUN or DONE is ignored; the mode cannot change mid-run.
- step or skip_layer in IDLE or DONE has no effect.
- reset takes priority over all inputs:
  - Next state is IDLE, all registers return to 0, and the mode register is cleared.
- While reset is high, layer_index, row_index and col_index read 0 combinationally in the same cycle. addr reads BASE in that cycle.
- Index registers are 32 bits. They never exceed LAYERS-1 / ROWS-1 / COLS-1.
- addr is combinational from the registered indices. The products are computed at 32 bits, then truncated.
- ROWS = 1 or COLS = 1: the inner wrap and the outer increment happen on the same step.

## Timing
- start sampled at edge N: valid, busy = 1 from N+1, indices (0,0,0).
- step or skip sampled at edge N: new indices and addr are visible after N, i.e. one cycle of latency.
- Back-to-back steps advance one element per cycle. A run of pure steps reaches DONE exactly LAYERS*ROWS*COLS accepted steps after start.
- Final step at edge N:
  - DONE for the cycle after N, with done = 1, valid = 0 and busy = 0.
  - IDLE after N+1. Earliest accepted restart is at edge N+2.
- reset asserted at edge N: all outputs are at reset values after N. Index outputs are already 0 during the reset-high cycle.

## Test plan
- Reset then start with col_major = 0, 18 steps (defaults) -> the triple sequence is (0,0,0), (0,0,1), (0,0,2), (0,1,0) … (1,2,2).
  - addr counts 0..17.
  - done pulses exactly once, one cycle after step 18.
  - Returns to IDLE.
- start with col_major = 1, 4 steps -> (0,0,0), (0,1,0), (0,2,0), (0,0,1), (0,1,1); addr values 0, 3, 6, 1, 4.
- In RUN at (0,1,2), assert step and skip_layer together -> next (1,0,0), addr 9, last_layer = 1.
  - skip_layer again -> DONE, done = 1.
- Mid-run at (1,2,1), addr 16, assert reset for one cycle:
  - Indices read 0 during the reset cycle.
  - State is IDLE after it, and a following step has no effect.
- Toggle col_major and pulse start during RUN -> the walk order and position are unchanged.
  - start held through DONE is ignored; start held into IDLE begins a new run at (0,0,0).
- ROWS = 1, COLS = 1, LAYERS = 3, BASE = 100 -> addr 100, 101, 102 on successive steps; the third step ends the run.

Source files
------------

// File: rtl/matrix_storage_sequencer.sv
// Walks LAYERS stacked ROWS x COLS matrices, one element per accepted step,
// emitting layer/row/column indices and the matching flat storage address.
module matrix_storage_sequencer #(
  parameter int          ROWS   = 3,
  parameter int          COLS   = 3,
  parameter int          LAYERS = 2,
  parameter int          ADDR_W = 16,
  parameter int unsigned BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              col_major,
  input  logic              step,
  input  logic              skip_layer,
  output logic [31:0]       layer_index,
  output logic [31:0]       row_index,
  output logic [31:0]       col_index,
  output logic [ADDR_W-1:0] addr,
  output logic              valid,
  output logic              last_layer,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [31:0] LAST_ROW   = 32'(ROWS - 1);
  localparam logic [31:0] LAST_COL   = 32'(COLS - 1);
  localparam logic [31:0] LAST_LAYER = 32'(LAYERS - 1);
  localparam logic [31:0] LAYER_SIZE = 32'(ROWS * COLS);
  localparam logic [31:0] ROW_SIZE   = 32'(COLS);
  localparam logic [31:0] BASE_ADDR  = 32'(BASE);

  state_t      state;
  logic        mode_q;
  logic [31:0] layer_q, row_q, col_q;
  logic        valid_q, busy_q, done_q, last_layer_q;

  logic [31:0] nxt_row, nxt_col, nxt_layer;
  logic        layer_inc, advance, end_run;
  logic [31:0] flat;

  // Next position within the walk; skip_layer overrides a simultaneous step.
  always_comb begin
    nxt_row   = row_q;
    nxt_col   = col_q;
    layer_inc = 1'b0;
    if (skip_layer) begin
      nxt_row   = '0;
      nxt_col   = '0;
      layer_inc = 1'b1;
    end else if (step) begin
      if (!mode_q) begin
        if (col_q == LAST_COL) begin
          nxt_col = '0;
          if (row_q == LAST_ROW) begin
            nxt_row   = '0;
            layer_inc = 1'b1;
          end else begin
            nxt_row = row_q + 32'd1;
          end
        end else begin
          nxt_col = col_q + 32'd1;
        end
      end else begin
        if (row_q == LAST_ROW) begin
          nxt_row = '0;
          if (col_q == LAST_COL) begin
            nxt_col   = '0;
            layer_inc = 1'b1;
          end else begin
            nxt_col = col_q + 32'd1;
          end
        end else begin
          nxt_row = row_q + 32'd1;
        end
      end
    end
  end

  assign advance   = step | skip_layer;
  assign nxt_layer = layer_inc ? layer_q + 32'd1 : layer_q;
  assign end_run   = layer_inc && (layer_q == LAST_LAYER);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      mode_q       <= 1'b0;
      layer_q      <= '0;
      row_q        <= '0;
      col_q        <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      last_layer_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state        <= RUN;
            mode_q       <= col_major;
            layer_q      <= '0;
            row_q        <= '0;
            col_q        <= '0;
            valid_q      <= 1'b1;
            busy_q       <= 1'b1;
            last_layer_q <= (LAST_LAYER == 32'd0);
          end
        end
        RUN: begin
          if (advance) begin
            if (end_run) begin
              state        <= DONE;
              layer_q      <= '0;
              row_q        <= '0;
              col_q        <= '0;
              valid_q      <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              last_layer_q <= 1'b0;
            end else begin
              layer_q      <= nxt_layer;
              row_q        <= nxt_row;
              col_q        <= nxt_col;
              last_layer_q <= (nxt_layer == LAST_LAYER);
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Indices are forced to zero while reset is held, ahead of the register update.
  assign layer_index = reset ? '0 : layer_q;
  assign row_index   = reset ? '0 : row_q;
  assign col_index   = reset ? '0 : col_q;

  assign flat = BASE_ADDR + layer_index * LAYER_SIZE + row_index * ROW_SIZE + col_index;
  assign addr = ADDR_W'(flat);

  assign valid      = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign last_layer = last_layer_q;

endmodule

// File: tb/tb_matrix_storage_sequencer.sv
// Randomised and directed bench for matrix_storage_sequencer: a default 3x3x2
// instance and a 1x1x3 instance at base 100 share stimulus, each with its own model.
module tb_matrix_storage_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic col_major = 1'b0;
  logic step = 1'b0;
  logic skip_layer = 1'b0;

  logic [31:0] layer0, row0, col0, layer1, row1, col1;
  logic [15:0] addr0, addr1;
  logic        valid0, last0, busy0, done0;
  logic        valid1, last1, busy1, done1;

  int n_cmp = 0;
  int n_err = 0;

  // Model state per instance: 0 idle, 1 run, 2 done; k is the linear element count.
  int m_state[2];
  int m_k[2];
  int m_mode[2];

  always #5 clk = ~clk;

  matrix_storage_sequencer #(.ROWS(3), .COLS(3), .LAYERS(2), .ADDR_W(16), .BASE(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .col_major(col_major), .step(step),
    .skip_layer(skip_layer), .layer_index(layer0), .row_index(row0), .col_index(col0),
    .addr(addr0), .valid(valid0), .last_layer(last0), .busy(busy0), .done(done0)
  );

  matrix_storage_sequencer #(.ROWS(1), .COLS(1), .LAYERS(3), .ADDR_W(16), .BASE(100)) dut1 (
    .clk(clk), .reset(reset), .start(start), .col_major(col_major), .step(step),
    .skip_layer(skip_layer), .layer_index(layer1), .row_index(row1), .col_index(col1),
    .addr(addr1), .valid(valid1), .last_layer(last1), .busy(busy1), .done(done1)
  );

  function automatic int p_rows(int i);   return (i == 0) ? 3 : 1;   endfunction
  function automatic int p_cols(int i);   return (i == 0) ? 3 : 1;   endfunction
  function automatic int p_layers(int i); return (i == 0) ? 2 : 3;   endfunction
  function automatic int p_base(int i);   return (i == 0) ? 0 : 100; endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input int i);
    int rc;
    rc = p_rows(i) * p_cols(i);
    if (reset) begin
      m_state[i] = 0; m_k[i] = 0; m_mode[i] = 0;
    end else begin
      case (m_state[i])
        0: if (start) begin m_state[i] = 1; m_k[i] = 0; m_mode[i] = int'(col_major); end
        1: if (skip_layer || step) begin
             if (skip_layer) m_k[i] = (m_k[i] / rc + 1) * rc;
             else m_k[i] = m_k[i] + 1;
             if (m_k[i] >= p_layers(i) * rc) begin m_state[i] = 2; m_k[i] = 0; end
           end
        default: m_state[i] = 0;
      endcase
    end
  endtask

  task automatic compare_one(input int i, input logic [31:0] gl, input logic [31:0] gr,
                             input logic [31:0] gc, input logic [15:0] ga, input logic gv,
                             input logic gll, input logic gb, input logic gd);
    int rc, rem, l, r, c, a;
    rc  = p_rows(i) * p_cols(i);
    l   = m_k[i] / rc;
    rem = m_k[i] % rc;
    if (m_mode[i] == 0) begin r = rem / p_cols(i); c = rem % p_cols(i); end
    else begin c = rem / p_rows(i); r = rem % p_rows(i); end
    check_eq($sformatf("u%0d.last_layer", i), 32'(gll), 32'((m_state[i] == 1) && (l == p_layers(i) - 1)));
    if (reset) begin l = 0; r = 0; c = 0; end
    a = (p_base(i) + l * rc + r * p_cols(i) + c) & 16'hFFFF;
    check_eq($sformatf("u%0d.layer", i), gl, 32'(l));
    check_eq($sformatf("u%0d.row", i),   gr, 32'(r));
    check_eq($sformatf("u%0d.col", i),   gc, 32'(c));
    check_eq($sformatf("u%0d.addr", i),  32'(ga), 32'(a));
    check_eq($sformatf("u%0d.valid", i), 32'(gv), 32'(m_state[i] == 1));
    check_eq($sformatf("u%0d.busy", i),  32'(gb), 32'(m_state[i] == 1));
    check_eq($sformatf("u%0d.done", i),  32'(gd), 32'(m_state[i] == 2));
  endtask

  task automatic compare_now();
    compare_one(0, layer0, row0, col0, addr0, valid0, last0, busy0, done0);
    compare_one(1, layer1, row1, col1, addr1, valid1, last1, busy1, done1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update(0);
    model_update(1);
    @(negedge clk);
    compare_now();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin m_state[i] = 0; m_k[i] = 0; m_mode[i] = 0; end
    @(negedge clk);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Row-major full run on both instances.
    start = 1'b1; col_major = 1'b0; tick(); start = 1'b0;
    step = 1'b1;
    for (int n = 0; n < 18; n++) tick();
    check_eq("rowmajor_done_pulse", 32'(done0), 32'd1);
    step = 1'b0;
    tick();
    check_eq("rowmajor_back_idle", 32'(busy0 | done0), 32'd0);

    // Column-major walk.
    start = 1'b1; col_major = 1'b1; tick(); start = 1'b0; col_major = 1'b0;
    step = 1'b1;
    for (int n = 0; n < 4; n++) tick();
    check_eq("colmajor_addr4", 32'(addr0), 32'd4);
    step = 1'b0;
    skip_layer = 1'b1; tick(); tick(); skip_layer = 1'b0;
    tick();

    // Step and skip together from (0,1,2).
    start = 1'b1; tick(); start = 1'b0;
    step = 1'b1;
    for (int n = 0; n < 5; n++) tick();
    skip_layer = 1'b1; tick();
    check_eq("skip_wins_addr", 32'(addr0), 32'd9);
    check_eq("skip_wins_last", 32'(last0), 32'd1);
    step = 1'b0; tick();
    check_eq("skip_to_done", 32'(done0), 32'd1);
    skip_layer = 1'b0; tick();

    // Reset mid-run at (1,2,1).
    start = 1'b1; tick(); start = 1'b0;
    step = 1'b1;
    for (int n = 0; n < 16; n++) tick();
    step = 1'b0;
    check_eq("mid_addr16", 32'(addr0), 32'd16);
    reset = 1'b1; #1;
    compare_now();
    check_eq("reset_row_comb", row0, 32'd0);
    tick(); reset = 1'b0;
    step = 1'b1; tick(); step = 1'b0;
    check_eq("step_after_reset", 32'(valid0), 32'd0);

    // start and col_major toggled mid-run, then start held through DONE into IDLE.
    start = 1'b1; tick(); start = 1'b0;
    step = 1'b1;
    for (int n = 0; n < 6; n++) begin
      start = 1'($urandom_range(0, 1)); col_major = 1'($urandom_range(0, 1)); tick();
    end
    start = 1'b1;
    for (int n = 0; n < 14; n++) tick();
    start = 1'b0; step = 1'b0; col_major = 1'b0;
    tick();

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 63) == 0);
      start      = ($urandom_range(0, 7) == 0);
      col_major  = 1'($urandom_range(0, 1));
      step       = 1'($urandom_range(0, 1));
      skip_layer = ($urandom_range(0, 15) == 0);
      #1 compare_now();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
